fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage sitting directly upstream of `Control_unit` and the register file. Owns the program counter, issues one-at-a-time requests to instruction memory over a req/gnt/rvalid handshake, and holds each fetched instruction stable with its decoded control fields until the datapath consumes it. On consume, the PC advances by 4, or to `PC + imm_ext` when `pc_src` is asserted.

## Interface
- `RESET_PC`, 32'h0000_1000: PC value loaded on reset.
- `NOP_INSTR`, 32'h0000_0013: value driven on `instr` while no valid instruction is held (`addi x0,x0,0`).

- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset. The same `rst` also resets instruction memory, so no stale response can survive reset.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out 32: fetch address; always equals `pc`.
- `imem_gnt` in 1: memory accepts the request in the cycle `imem_req && imem_gnt`.
- `imem_rvalid` in 1: read data valid; arrives 1 or more cycles after the grant.
- `imem_rdata` in 32: instruction word.
- `stall` in 1: datapath not ready to consume.
- `pc_src` in 1: from `Control_unit` (Branch & zero); sampled only on consume.
- `imm_ext` in 32: sign-extended branch offset; sampled only on consume.
- `pc` out 32: address of the held or in-flight instruction.
- `instr` out 32: held instruction.
- `instr_valid` out 1: `instr` is valid.
- `op_code` out 7: `instr[6:0]`.
- `funct3` out 3: `instr[14:12]`.
- `funct7` out 1: `instr[30]`.
- `fetch_err` out 1: misaligned target trap (see Configuration).

## Operation
- FSM states: BOOT, REQ, WAIT, HOLD, ERR.
- **BOOT**, entered on reset:
  - `imem_req`=0.
  - Advances to REQ on the next cycle.
- **REQ**:
  - `imem_req`=1, `imem_addr`=`pc`.
  - On `imem_gnt` → WAIT; otherwise stay.
- **WAIT**:
  - `imem_req`=0.
  - On `imem_rvalid`: `instr` ← `imem_rdata`, `instr_valid` ← 1, → HOLD.
- **HOLD**:
  - `instr`, `pc` and the decoded fields are stable.
  - Consume = `instr_valid && !stall`.
  - On consume: `pc` ← `pc_src ? pc + imm_ext : pc + 4`, `instr_valid` ← 0, `instr` ← `NOP_INSTR`, → REQ.
  - While `stall`=1: hold everything.
- **ERR**: see Configuration. Exit only by reset.
- Decoded fields are purely combinational from `instr`. They read the `NOP_INSTR` fields when invalid.
- Arithmetic is 32-bit modulo. `pc + 4` from 32'hFFFF_FFFC wraps to 0; branch targets wrap the same way, with no flag.
- `imem_rvalid` outside WAIT is ignored. `imem_gnt` outside REQ is ignored.
- `pc_src`/`imm_ext` are ignored except in the consume cycle.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, `instr`=`NOP_INSTR`.
  - `instr_valid`=0, `imem_req`=0, `fetch_err`=0.
  - State = BOOT.
- Reset has priority over every event, in any state, including mid-WAIT and mid-HOLD.
- First `imem_req` is in the 2nd cycle after `rst` deasserts.
- Per-instruction latency with gnt same cycle and rvalid one cycle later:
  - REQ (1 cycle) + WAIT (1 cycle) → `instr_valid` rises at the start of the 3rd cycle.
  - Throughput: one instruction per 3 cycles with `stall`=0.
- The `pc` update on consume is visible in the following cycle. `imem_addr` in that REQ cycle already carries the new `pc`.
- Simultaneous `stall`=1 and `pc_src`=1: no consume, so no PC change.

## Configuration
- `FETCH_MISALIGN_TRAP_EN`, defined:
  - On consume, if the computed next PC has `[1:0]` ≠ 0: `pc` is not updated, `instr_valid` ← 0, and → ERR.
  - In ERR: `fetch_err`=1, `imem_req`=0, until reset.
- `FETCH_MISALIGN_TRAP_EN`, undefined:
  - The next PC is loaded with `[1:0]` forced to 2'b00.
  - `fetch_err` is tied 0 and ERR is unreachable.

## Test plan
- Reset then free-run, memory with gnt=1 and rvalid 1 cycle later → `imem_addr` sequence 0x1000, 0x1004, 0x1008; `instr_valid` pulses every 3 cycles; `instr` matches memory.
- `stall`=1 for 5 cycles in HOLD with `instr`=0x00500093 → `instr`/`pc`/`op_code`=0x13 held, no `imem_req`; on release, the next address is `pc` + 4.
- Consume at `pc`=0x1010 with `pc_src`=1, `imm_ext`=0xFFFFFFF0 → next `imem_addr`=0x1000. With `pc_src`=0 and the same `imm_ext` → 0x1014.
- `imem_gnt` withheld 4 cycles, then rvalid 3 cycles after the grant; a spurious `imem_rvalid` injected in REQ → ignored; the correct word is captured only in WAIT.
- `rst` asserted during WAIT → next cycle `pc`=0x1000, `instr_valid`=0, state BOOT; fetch restarts from 0x1000.
- Consume with `pc_src`=1, `imm_ext`=0x2 at `pc`=0x1000:
  - Macro defined → `fetch_err`=1, `pc` stays 0x1000, no further requests.
  - Macro undefined → `imem_addr`=0x1000.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches one word at a time over req/gnt/rvalid,
// holds it with decoded fields until consumed. Optional misaligned-target trap: FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_1000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        pc_src,
   input  logic [31:0] imm_ext,
   output logic [31:0] pc,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [6:0]  op_code,
   output logic [2:0]  funct3,
   output logic        funct7,
   output logic        fetch_err
);

   typedef enum logic [2:0] {BOOT, REQ, WAIT, HOLD, ERR} state_t;

   state_t      state, state_nxt;
   logic        consume;
   logic        misalign;
   logic [31:0] target;
   logic [31:0] pc_nxt;

   assign consume = (state == HOLD) && instr_valid && !stall;
   assign target  = pc_src ? pc + imm_ext : pc + 32'd4;

`ifdef FETCH_MISALIGN_TRAP_EN
   assign misalign = |target[1:0];
   assign pc_nxt   = target;
`else
   // Without the trap a misaligned target is silently rounded down to a word boundary.
   assign misalign = 1'b0;
   assign pc_nxt   = target & ~32'h3;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= BOOT;
         pc          <= RESET_PC;
         instr       <= NOP_INSTR;
         instr_valid <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == WAIT && imem_rvalid) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
         end
         if (consume) begin
            instr       <= NOP_INSTR;
            instr_valid <= 1'b0;
            if (!misalign) pc <= pc_nxt;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         BOOT:    state_nxt = REQ;
         REQ:     if (imem_gnt) state_nxt = WAIT;
         WAIT:    if (imem_rvalid) state_nxt = HOLD;
         HOLD:    if (consume) state_nxt = misalign ? ERR : REQ;
         ERR:     state_nxt = ERR;
         default: state_nxt = BOOT;
      endcase
   end

   always_comb begin
      imem_req  = (state == REQ);
      imem_addr = pc;
`ifdef FETCH_MISALIGN_TRAP_EN
      fetch_err = (state == ERR);
`else
      fetch_err = 1'b0;
`endif
   end

   assign op_code = instr[6:0];
   assign funct3  = instr[14:12];
   assign funct7  = instr[30];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory handshake is driven step by step from one initial block.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        pc_src;
   logic [31:0] imm_ext;
   logic [31:0] pc;
   logic [31:0] instr;
   logic        instr_valid;
   logic [6:0]  op_code;
   logic [2:0]  funct3;
   logic        funct7;
   logic        fetch_err;

   int ncmp = 0;
   int nerr = 0;

   fetch_unit dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .stall(stall), .pc_src(pc_src), .imm_ext(imm_ext),
      .pc(pc), .instr(instr), .instr_valid(instr_valid),
      .op_code(op_code), .funct3(funct3), .funct7(funct7), .fetch_err(fetch_err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Enter in REQ at a negedge; leave in HOLD with the word checked.
   task automatic fetch(input logic [31:0] a, input logic [31:0] w, input int gw, input int rw,
                        input bit spur);
      for (int i = 0; i < gw; i++) begin
         chk("req_held", imem_req, 1'b1);
         chk("addr_held", imem_addr, a);
         imem_gnt    = 1'b0;
         imem_rvalid = spur && (i == 0);
         imem_rdata  = 32'hDEAD_BEEF;
         step();
         imem_rvalid = 1'b0;
      end
      chk("req", imem_req, 1'b1);
      chk("addr", imem_addr, a);
      imem_gnt = 1'b1;
      step();
      imem_gnt = 1'b0;
      for (int i = 1; i < rw; i++) begin
         chk("wait_noreq", imem_req, 1'b0);
         chk("wait_novalid", instr_valid, 1'b0);
         step();
      end
      imem_rvalid = 1'b1;
      imem_rdata  = w;
      step();
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      chk("valid", instr_valid, 1'b1);
      chk("instr", instr, w);
      chk("pc", pc, a);
   endtask

   task automatic consume(input bit src, input logic [31:0] imm, input logic [31:0] nxt);
      stall   = 1'b0;
      pc_src  = src;
      imm_ext = imm;
      step();
      pc_src  = 1'b0;
      imm_ext = 32'h0;
      chk("cons_valid", instr_valid, 1'b0);
      chk("cons_nop", instr, 32'h13);
      chk("cons_req", imem_req, 1'b1);
      chk("cons_addr", imem_addr, nxt);
   endtask

   initial begin
      rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
      stall = 1'b0; pc_src = 1'b0; imm_ext = 32'h0;
      step(); step();
      chk("rst_pc", pc, 32'h1000);
      chk("rst_instr", instr, 32'h13);
      chk("rst_valid", instr_valid, 1'b0);
      chk("rst_req", imem_req, 1'b0);
      chk("rst_err", fetch_err, 1'b0);
      chk("rst_op", op_code, 7'h13);
      rst = 1'b0;
      step();

      // free run
      fetch(32'h1000, 32'h0010_0093, 0, 1, 1'b0);
      consume(1'b0, 32'h0, 32'h1004);
      fetch(32'h1004, 32'h40B5_5533, 0, 1, 1'b0);
      chk("dec_op", op_code, 7'h33);
      chk("dec_f3", funct3, 3'h5);
      chk("dec_f7", funct7, 1'b1);
      consume(1'b0, 32'h0, 32'h1008);
      fetch(32'h1008, 32'h0050_0093, 0, 1, 1'b0);

      // stall in HOLD, with a branch request that must be ignored
      stall = 1'b1; pc_src = 1'b1; imm_ext = 32'h100;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("stall_instr", instr, 32'h0050_0093);
         chk("stall_pc", pc, 32'h1008);
         chk("stall_op", op_code, 7'h13);
         chk("stall_req", imem_req, 1'b0);
         chk("stall_valid", instr_valid, 1'b1);
      end
      consume(1'b0, 32'h0, 32'h100C);

      // branch targets
      fetch(32'h100C, 32'h0000_0013, 0, 1, 1'b0);
      consume(1'b0, 32'h0, 32'h1010);
      fetch(32'h1010, 32'h0000_0063, 0, 1, 1'b0);
      consume(1'b1, 32'hFFFF_FFF0, 32'h1000);
      fetch(32'h1000, 32'h0000_0063, 0, 1, 1'b0);
      consume(1'b1, 32'h10, 32'h1010);
      fetch(32'h1010, 32'h0000_0063, 0, 1, 1'b0);
      consume(1'b0, 32'hFFFF_FFF0, 32'h1014);

      // slow grant, slow data, spurious rvalid in REQ
      fetch(32'h1014, 32'h0020_8133, 4, 3, 1'b1);
      consume(1'b0, 32'h0, 32'h1018);

      // wrap-around
      fetch(32'h1018, 32'h0000_0063, 0, 1, 1'b0);
      consume(1'b1, 32'hFFFF_EFE4, 32'hFFFF_FFFC);
      fetch(32'hFFFF_FFFC, 32'h0000_0013, 0, 1, 1'b0);
      consume(1'b0, 32'h0, 32'h0);

      // reset mid-WAIT, with rvalid colliding with reset
      imem_gnt = 1'b1;
      step();
      imem_gnt = 1'b0;
      rst = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
      step();
      imem_rvalid = 1'b0;
      chk("wrst_pc", pc, 32'h1000);
      chk("wrst_valid", instr_valid, 1'b0);
      chk("wrst_instr", instr, 32'h13);
      chk("wrst_req", imem_req, 1'b0);
      rst = 1'b0;
      step();
      fetch(32'h1000, 32'h0000_0063, 0, 1, 1'b0);

      // misaligned branch target
`ifdef FETCH_MISALIGN_TRAP_EN
      stall = 1'b0; pc_src = 1'b1; imm_ext = 32'h2;
      step();
      pc_src = 1'b0; imm_ext = 32'h0; imem_gnt = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("trap_err", fetch_err, 1'b1);
         chk("trap_pc", pc, 32'h1000);
         chk("trap_req", imem_req, 1'b0);
         chk("trap_valid", instr_valid, 1'b0);
         step();
      end
      imem_gnt = 1'b0;
`else
      consume(1'b1, 32'h2, 32'h1000);
      chk("noerr", fetch_err, 1'b0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
